// File: rtl/ccg_sweep_ctrl_if.sv
// Host/block-side signal bundle for ccg_sweep_ctrl: run handshake, truth table,
// block stimulus/response and the sweep results.
interface ccg_sweep_ctrl_if #(
   parameter int unsigned N_IN  = 4,
   parameter int unsigned N_OUT = 4,
   parameter int unsigned SIG_W = 16
);
   logic                        start;
   logic                        abort;
   logic [N_OUT*(2**N_IN)-1:0]  exp_tt_i;
   logic [N_OUT-1:0]            f_i;
   logic [N_IN-1:0]             x_o;
   logic                        busy;
   logic                        done;
   logic                        pass;
   logic [N_IN:0]               mismatch_cnt;
   logic [N_IN-1:0]             first_fail_idx;
   logic [SIG_W-1:0]            sig_o;

   modport master (
      output start, abort, exp_tt_i, f_i,
      input  x_o, busy, done, pass, mismatch_cnt, first_fail_idx, sig_o
   );

   modport slave (
      input  start, abort, exp_tt_i, f_i,
      output x_o, busy, done, pass, mismatch_cnt, first_fail_idx, sig_o
   );
endinterface

// File: rtl/ccg_sweep_ctrl.sv
// Exhaustive sweep sequencer: drives every input vector of a small combinational
// block, compares each settled response to a truth table and folds it into a MISR.
module ccg_sweep_ctrl #(
   parameter int unsigned       N_IN   = 4,
   parameter int unsigned       N_OUT  = 4,
   parameter int unsigned       SETTLE = 1,
   parameter int unsigned       SIG_W  = 16,
   parameter logic [SIG_W-1:0]  POLY   = 16'h1021
) (
   input logic              clk,
   input logic              rst_n,
   ccg_sweep_ctrl_if.slave  bus
);

   typedef enum logic [1:0] {IDLE, APPLY, SAMPLE, FINISH} state_t;

   localparam logic [N_IN-1:0] LAST_IDX  = '1;
   localparam logic [3:0]      SETTLE_LD = 4'(SETTLE - 1);

   state_t            state, state_n;
   logic [N_IN-1:0]   idx, idx_n;
   logic [3:0]        settle_cnt, settle_cnt_n;
   logic [N_IN:0]     cnt, cnt_n;
   logic [N_IN-1:0]   ffi, ffi_n;
   logic [SIG_W-1:0]  sig, sig_n, sig_step;
   logic              pass_q, pass_n;
   logic [N_OUT-1:0]  exp_vec;
   logic              miss;

   assign exp_vec  = bus.exp_tt_i[int'(idx)*N_OUT +: N_OUT];
   assign miss     = (bus.f_i != exp_vec);
   assign sig_step = {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : '0) ^ SIG_W'(bus.f_i);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         idx        <= '0;
         settle_cnt <= '0;
         cnt        <= '0;
         ffi        <= '0;
         sig        <= '0;
         pass_q     <= 1'b0;
      end else begin
         state      <= state_n;
         idx        <= idx_n;
         settle_cnt <= settle_cnt_n;
         cnt        <= cnt_n;
         ffi        <= ffi_n;
         sig        <= sig_n;
         pass_q     <= pass_n;
      end
   end

   always_comb begin
      state_n      = state;
      idx_n        = idx;
      settle_cnt_n = settle_cnt;
      cnt_n        = cnt;
      ffi_n        = ffi;
      sig_n        = sig;
      pass_n       = pass_q;
      case (state)
         IDLE: begin
            if (bus.start) begin
               state_n      = APPLY;
               idx_n        = '0;
               settle_cnt_n = SETTLE_LD;
               cnt_n        = '0;
               ffi_n        = '0;
               sig_n        = '0;
               pass_n       = 1'b0;
            end
         end
         APPLY: begin
            if (bus.abort) begin
               state_n = IDLE;
               pass_n  = 1'b0;
            end else if (settle_cnt == 4'd0) begin
               state_n = SAMPLE;
            end else begin
               settle_cnt_n = settle_cnt - 4'd1;
            end
         end
         SAMPLE: begin
            // An abort here drops the in-flight sample; results stay as of the previous vector.
            if (bus.abort) begin
               state_n = IDLE;
               pass_n  = 1'b0;
            end else begin
               if (miss) begin
                  cnt_n = cnt + (N_IN+1)'(1);
                  if (cnt == '0) ffi_n = idx;
               end
               sig_n = sig_step;
               if (idx == LAST_IDX) begin
                  state_n = FINISH;
                  pass_n  = (cnt_n == '0);
               end else begin
                  idx_n        = idx + N_IN'(1);
                  settle_cnt_n = SETTLE_LD;
                  state_n      = APPLY;
               end
            end
         end
         FINISH: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   assign bus.x_o            = (state == APPLY || state == SAMPLE) ? idx : '0;
   assign bus.busy           = (state == APPLY || state == SAMPLE);
   assign bus.done           = (state == FINISH);
   assign bus.pass           = pass_q;
   assign bus.mismatch_cnt   = cnt;
   assign bus.first_fail_idx = ffi;
   assign bus.sig_o          = sig;

endmodule

// File: tb/tb_ccg_sweep_ctrl.sv
// Self-checking bench for ccg_sweep_ctrl: scoreboard of expected sweep results,
// one DUT with SETTLE=1 (f_i tied to x_o) and one with SETTLE=3 (driven f_i).
module tb_ccg_sweep_ctrl;

   localparam logic [15:0] POLY = 16'h1021;

   typedef struct {
      logic [4:0]  cnt;
      logic [3:0]  ffi;
      logic        pass;
      logic [15:0] sig;
   } exp_t;

   logic        clk    = 1'b0;
   logic        rst_n  = 1'b0;
   logic        start1 = 1'b0;
   logic        abort1 = 1'b0;
   logic        start3 = 1'b0;
   logic [63:0] exp_r  = '0;
   logic [3:0]  f3     = '0;
   logic [63:0] tt_ok, tt_bad;

   int   checks = 0;
   int   errors = 0;
   exp_t sb[$];

   always #5 clk = ~clk;

   ccg_sweep_ctrl_if #(.N_IN(4), .N_OUT(4), .SIG_W(16)) bus1 ();
   ccg_sweep_ctrl_if #(.N_IN(4), .N_OUT(4), .SIG_W(16)) bus3 ();

   assign bus1.start    = start1;
   assign bus1.abort    = abort1;
   assign bus1.exp_tt_i = exp_r;
   assign bus1.f_i      = bus1.x_o;
   assign bus3.start    = start3;
   assign bus3.abort    = 1'b0;
   assign bus3.exp_tt_i = exp_r;
   assign bus3.f_i      = f3;

   ccg_sweep_ctrl #(.N_IN(4), .N_OUT(4), .SETTLE(1), .SIG_W(16), .POLY(POLY)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .bus(bus1.slave));
   ccg_sweep_ctrl #(.N_IN(4), .N_OUT(4), .SETTLE(3), .SIG_W(16), .POLY(POLY)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .bus(bus3.slave));

   // Result after the first nsamp vectors, with the block answering f = vector index.
   function automatic exp_t model(input logic [63:0] tt, input int nsamp);
      exp_t e;
      logic [3:0] f;
      e.cnt = '0;
      e.ffi = '0;
      e.sig = '0;
      for (int k = 0; k < nsamp; k++) begin
         f = 4'(k);
         if (f !== tt[k*4 +: 4]) begin
            if (e.cnt == 5'd0) e.ffi = 4'(k);
            e.cnt = e.cnt + 5'd1;
         end
         e.sig = (e.sig << 1) ^ (e.sig[15] ? POLY : 16'h0000) ^ 16'(f);
      end
      e.pass = (e.cnt == 5'd0);
      return e;
   endfunction

   task automatic sweep_bus1(input logic [63:0] tt, input int pulse_m, input string tag);
      exp_t e;
      int   m;
      bit   seen;
      exp_r = tt;
      sb.push_back(model(tt, 16));
      @(negedge clk) start1 = 1'b1;
      @(posedge clk);
      #1 start1 = 1'b0;
      m    = 1;
      seen = 1'b0;
      while (!seen && m <= 45) begin
         start1 = (m == pulse_m);
         if (bus1.done === 1'b1) begin
            seen = 1'b1;
            e    = sb.pop_front();
            checks++;
            if (m != 33) begin
               errors++; $display("FAIL %s latency: got %0d expected 33", tag, m);
            end
            checks++;
            if (bus1.mismatch_cnt !== e.cnt) begin
               errors++; $display("FAIL %s mismatch_cnt: got %0d expected %0d", tag, bus1.mismatch_cnt, e.cnt);
            end
            checks++;
            if (bus1.first_fail_idx !== e.ffi) begin
               errors++; $display("FAIL %s first_fail_idx: got %0d expected %0d", tag, bus1.first_fail_idx, e.ffi);
            end
            checks++;
            if (bus1.pass !== e.pass) begin
               errors++; $display("FAIL %s pass: got %0b expected %0b", tag, bus1.pass, e.pass);
            end
            checks++;
            if (bus1.sig_o !== e.sig) begin
               errors++; $display("FAIL %s sig_o: got %04h expected %04h", tag, bus1.sig_o, e.sig);
            end
            checks++;
            if ({bus1.busy, bus1.x_o} !== 5'b0_0000) begin
               errors++; $display("FAIL %s finish busy/x_o: got %0b/%0d expected 0/0", tag, bus1.busy, bus1.x_o);
            end
         end else begin
            if (m <= 32) begin
               checks++;
               if ({bus1.busy, bus1.x_o} !== {1'b1, 4'((m-1)/2)}) begin
                  errors++;
                  $display("FAIL %s step %0d busy/x_o: got %0b/%0d expected 1/%0d", tag, m, bus1.busy, bus1.x_o, (m-1)/2);
               end
            end
            @(posedge clk);
            #1 m++;
         end
      end
      start1 = 1'b0;
      if (!seen) begin
         checks++; errors++;
         $display("FAIL %s done timeout: got no done expected done at 33", tag);
         e = sb.pop_front();
      end else begin
         @(posedge clk);
         #1 checks++;
         if ({bus1.done, bus1.busy, bus1.pass} !== {1'b0, 1'b0, e.pass}) begin
            errors++;
            $display("FAIL %s after_done done/busy/pass: got %0b%0b%0b expected 00%0b", tag, bus1.done, bus1.busy, bus1.pass, e.pass);
         end
      end
   endtask

   task automatic test_reset();
      #1 checks++;
      if ({bus1.x_o, bus1.busy, bus1.done, bus1.pass, bus1.mismatch_cnt, bus1.first_fail_idx, bus1.sig_o} !== '0) begin
         errors++; $display("FAIL reset_dut1: got nonzero outputs expected all 0 (sig %04h)", bus1.sig_o);
      end
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1 checks++;
      if ({bus3.x_o, bus3.busy, bus3.done, bus3.pass, bus3.mismatch_cnt, bus3.first_fail_idx, bus3.sig_o} !== '0) begin
         errors++; $display("FAIL reset_dut3_idle: got nonzero outputs expected all 0 (sig %04h)", bus3.sig_o);
      end
      checks++;
      if ({bus1.busy, bus1.done, bus1.x_o} !== '0) begin
         errors++; $display("FAIL reset_idle_dut1: got busy %0b done %0b x %0d expected 0", bus1.busy, bus1.done, bus1.x_o);
      end
   endtask

   task automatic test_clean_sweep();
      sweep_bus1(tt_ok, 0, "clean");
   endtask

   task automatic test_mismatch();
      sweep_bus1(tt_bad, 0, "mismatch");
   endtask

   task automatic test_settle3();
      exp_t       e;
      int         m;
      bit         seen;
      logic [3:0] xe;
      exp_r = tt_ok;
      sb.push_back(model(tt_ok, 16));
      @(negedge clk) start3 = 1'b1;
      @(posedge clk);
      #1 start3 = 1'b0;
      m    = 1;
      seen = 1'b0;
      while (!seen && m <= 75) begin
         xe = (m <= 64) ? 4'((m-1)/4) : 4'd0;
         f3 = ((m-1) % 4 == 3) ? xe : ~xe;
         if (bus3.done === 1'b1) begin
            seen = 1'b1;
            e    = sb.pop_front();
            checks++;
            if (m != 65) begin
               errors++; $display("FAIL settle3 latency: got %0d expected 65", m);
            end
            checks++;
            if ({bus3.pass, bus3.mismatch_cnt} !== {e.pass, e.cnt}) begin
               errors++; $display("FAIL settle3 pass/cnt: got %0b/%0d expected %0b/%0d", bus3.pass, bus3.mismatch_cnt, e.pass, e.cnt);
            end
            checks++;
            if (bus3.sig_o !== e.sig) begin
               errors++; $display("FAIL settle3 sig_o: got %04h expected %04h", bus3.sig_o, e.sig);
            end
         end else begin
            if (m <= 64) begin
               checks++;
               if ({bus3.busy, bus3.x_o} !== {1'b1, xe}) begin
                  errors++; $display("FAIL settle3 step %0d busy/x_o: got %0b/%0d expected 1/%0d", m, bus3.busy, bus3.x_o, xe);
               end
            end
            @(posedge clk);
            #1 m++;
         end
      end
      if (!seen) begin
         checks++; errors++;
         $display("FAIL settle3 done timeout: got no done expected done at 65");
         e = sb.pop_front();
      end
      f3 = '0;
   endtask

   task automatic test_abort();
      exp_t e;
      bit   any_done;
      exp_r = tt_ok;
      e     = model(tt_ok, 7);
      @(negedge clk) start1 = 1'b1;
      @(posedge clk);
      #1 start1 = 1'b0;
      repeat (14) @(posedge clk);
      #1 checks++;
      if (bus1.x_o !== 4'd7) begin
         errors++; $display("FAIL abort setup x_o: got %0d expected 7", bus1.x_o);
      end
      abort1 = 1'b1;
      @(posedge clk);
      #1 abort1 = 1'b0;
      checks++;
      if ({bus1.busy, bus1.x_o, bus1.done, bus1.pass} !== 7'b0) begin
         errors++; $display("FAIL abort outputs busy/x/done/pass: got %0b/%0d/%0b/%0b expected 0/0/0/0", bus1.busy, bus1.x_o, bus1.done, bus1.pass);
      end
      checks++;
      if ({bus1.mismatch_cnt, bus1.sig_o} !== {e.cnt, e.sig}) begin
         errors++; $display("FAIL abort partial cnt/sig: got %0d/%04h expected %0d/%04h", bus1.mismatch_cnt, bus1.sig_o, e.cnt, e.sig);
      end
      any_done = 1'b0;
      repeat (40) begin
         @(posedge clk);
         #1 if (bus1.done === 1'b1 || bus1.busy === 1'b1) any_done = 1'b1;
      end
      checks++;
      if (any_done) begin
         errors++; $display("FAIL abort no_done: got done/busy activity expected none");
      end
      sweep_bus1(tt_ok, 0, "after_abort");
   endtask

   task automatic test_back_to_back();
      sweep_bus1(tt_ok, 7, "restart_ignored");
      sweep_bus1(tt_bad, 33, "start_in_finish");
      sweep_bus1(tt_ok, 0, "back_to_back");
   endtask

   task automatic test_reset_mid_sweep();
      exp_t e;
      bit   act;
      exp_r = tt_bad;
      e     = model(tt_bad, 10);
      @(negedge clk) start1 = 1'b1;
      @(posedge clk);
      #1 start1 = 1'b0;
      repeat (20) @(posedge clk);
      #1 checks++;
      if ({bus1.x_o, bus1.mismatch_cnt, bus1.first_fail_idx} !== {4'd10, e.cnt, e.ffi}) begin
         errors++; $display("FAIL rst_mid setup x/cnt/ffi: got %0d/%0d/%0d expected 10/%0d/%0d", bus1.x_o, bus1.mismatch_cnt, bus1.first_fail_idx, e.cnt, e.ffi);
      end
      rst_n = 1'b0;
      #1 checks++;
      if ({bus1.x_o, bus1.busy, bus1.done, bus1.pass, bus1.mismatch_cnt, bus1.first_fail_idx, bus1.sig_o} !== '0) begin
         errors++; $display("FAIL rst_mid async clear: got x %0d cnt %0d ffi %0d sig %04h expected all 0", bus1.x_o, bus1.mismatch_cnt, bus1.first_fail_idx, bus1.sig_o);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      act = 1'b0;
      repeat (6) begin
         @(posedge clk);
         #1 if (bus1.busy !== 1'b0 || bus1.done !== 1'b0 || bus1.x_o !== 4'd0) act = 1'b1;
      end
      checks++;
      if (act) begin
         errors++; $display("FAIL rst_mid stays_idle: got activity expected idle");
      end
      sweep_bus1(tt_ok, 0, "after_reset");
   endtask

   initial begin
      for (int k = 0; k < 16; k++) tt_ok[k*4 +: 4] = 4'(k);
      tt_bad          = tt_ok;
      tt_bad[20 +: 4] = ~4'd5;
      tt_bad[36 +: 4] = ~4'd9;
      exp_r           = tt_ok;
      test_reset();
      test_clean_sweep();
      test_mismatch();
      test_settle3();
      test_abort();
      test_back_to_back();
      test_reset_mid_sweep();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no completion expected finish before 200000");
      $fatal(1);
   end

endmodule

// File: doc/ccg_sweep_ctrl.md
Name: ccg_sweep_ctrl

Overview:
- Sequencer that exhaustively exercises one small combinational logic block with N_IN inputs and N_OUT outputs.
- Drives every input vector 0..2^N_IN-1 in ascending order and waits a programmable settle time before sampling the outputs.
- Compares each sample against a supplied truth table, counts mismatches, records the first failing vector and folds all samples into a MISR signature.
- Sits between a test/host controller (start/done handshake) and the combinational block under exercise.

Parameters:
- N_IN, 4, number of block inputs; sweep length 2^N_IN vectors.
- N_OUT, 4, number of block outputs.
- SETTLE, 1, cycles x_o is held before sampling; legal range 1..15.
- SIG_W, 16, MISR width; must be >= N_OUT.
- POLY, 16'h1021, MISR feedback polynomial, SIG_W bits.

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  run request, sampled in IDLE only.
- abort  input  1  cancel the current run.
- exp_tt_i  input  N_OUT*2^N_IN  expected outputs; vector k occupies bits [k*N_OUT +: N_OUT].
- f_i  input  N_OUT  outputs of the combinational block.
- x_o  output  N_IN  input vector driven to the block.
- busy  output  1  high from start accept until done.
- done  output  1  one-cycle pulse at end of a completed sweep.
- pass  output  1  valid from done onward; 1 when mismatch_cnt==0.
- mismatch_cnt  output  N_IN+1  number of failing vectors.
- first_fail_idx  output  N_IN  index of the first failing vector; 0 if none.
- sig_o  output  SIG_W  final MISR signature.

Behaviour:
- Reset values: x_o=0, busy=0, done=0, pass=0, mismatch_cnt=0, first_fail_idx=0, sig_o=0, state=IDLE, idx=0, wait counter=0.
- States: IDLE, APPLY, SAMPLE, FINISH.
- IDLE:
  - x_o=0.
  - Result outputs keep the last run's values.
  - On start=1: next state APPLY, idx=0, busy=1, wait counter=SETTLE-1.
  - On the same edge, clear mismatch_cnt, first_fail_idx, sig_o and pass to 0.
- APPLY:
  - x_o=idx.
  - Wait counter decrements each cycle; go to SAMPLE when the counter is 0.
  - Total time in APPLY is exactly SETTLE cycles.
- SAMPLE (one cycle, x_o=idx still held):
  - f_i is compared against exp_tt_i[idx*N_OUT +: N_OUT].
  - On a miscompare: mismatch_cnt increments; if mismatch_cnt was 0, first_fail_idx=idx.
  - MISR update: sig = (sig<<1) ^ (sig[SIG_W-1] ? POLY : 0) ^ zero-extended f_i.
  - If idx==2^N_IN-1, next state is FINISH; otherwise idx+1, wait counter reloads to SETTLE-1, next state APPLY.
- FINISH (one cycle):
  - done=1, busy=0, pass=(mismatch_cnt==0), x_o=0.
  - Next state IDLE.
- Latency: done is high exactly 2^N_IN*(SETTLE+1)+1 cycles after the cycle start was accepted. Defaults give 33.
- f_i is ignored outside SAMPLE. exp_tt_i must be stable while busy=1.
- start while busy=1 is ignored; no restart and no queuing.
- start in the same cycle as FINISH is ignored; start is accepted only in IDLE.
- abort in APPLY or SAMPLE: next state IDLE, busy=0, x_o=0, no done pulse, pass=0, partial counters and signature retained. abort in IDLE or FINISH has no effect.
- abort and start in the same IDLE cycle: start wins.
- rst_n low at any point, including mid-sweep: immediate return to all reset values with no done pulse. The run restarts only on a new start after release.
- No counter wraps: mismatch_cnt width holds 2^N_IN, idx is a terminal count.

Test Plan:
1. Defaults, f_i tied to x_o, exp_tt_i[k*4 +: 4]=k. Pulse start → x_o steps 0..15 with each value held 2 cycles; done exactly 33 cycles after start; pass=1, mismatch_cnt=0, first_fail_idx=0; sig_o matches the bench MISR model.
2. Same as 1 but exp_tt_i entries 5 and 9 inverted → mismatch_cnt=2, first_fail_idx=5, pass=0; sig_o identical to run 1, since the signature depends on f_i only.
3. SETTLE=3, f_i set to garbage during APPLY and correct only in the SAMPLE cycle → pass=1; done 65 cycles after start.
4. Assert abort when x_o=7 → next cycle busy=0 and x_o=0; no done pulse. A following start runs a full clean sweep with pass=1.
5. Pulse start again at x_o=3 mid-run → no effect; sweep completes at the original 33-cycle mark.
6. Drop rst_n low at x_o=10 for 1 cycle → all outputs return to 0 asynchronously. After release, stay in IDLE until start; the next run behaves as scenario 1.
